mc_pm_seq: RTL and testbench
============================

# mc_pm_seq

Power-management sequencer that sits directly upstream of the memory controller's suspend/resume port. It turns a system-level sleep/wake request into the controller's susp_req_i / resume_req_i handshake. It also drains the WISHBONE side before suspending, gates power to the non-retained logic while suspended, and issues the single-cycle pr_restore pulse that reloads retention registers before resume.

## Interface
- OFF_MIN_CYC, 4: minimum power-off dwell; the PGATE state lasts at least OFF_MIN_CYC+1 cycles.
- PWRUP_CYC, 8: power-rail settle time; the PWRUP state lasts exactly PWRUP_CYC+1 cycles.
- CNT_W, 8: dwell counter width. Both cycle parameters must be < 2^CNT_W.

Ports:
- clk_i  in  1  system clock, same clock as the controller's WISHBONE side.
- rst_i  in  1  reset, asynchronous, active-high.
- sleep_req_i  in  1  level request from the system PMU to enter sleep.
- wake_req_i  in  1  wake request, level or pulse; it is latched internally.
- wb_cyc_i  in  1  WISHBONE cycle-in-progress, observed from the bus master.
- suspended_i  in  1  the controller's suspended_o.
- susp_req_o  out  1  drives the controller's susp_req_i.
- resume_req_o  out  1  drives the controller's resume_req_i.
- pr_restore_o  out  1  retention restore pulse.
- pwr_off_o  out  1  power-gate enable for non-retained logic.
- wb_hold_o  out  1  forbids the master from starting new WISHBONE cycles.
- asleep_o  out  1  status flag, high while in the PGATE state.

## Operation
States: RUN, DRAIN, SUSP, PGATE, PWRUP, RESTORE, RESUME. All outputs are registered decodes of the state:
- susp_req_o = SUSP
- pwr_off_o = asleep_o = PGATE
- pr_restore_o = RESTORE
- resume_req_o = RESUME
- wb_hold_o = any state except RUN

Transitions:
- RUN -> DRAIN when sleep_req_i && armed. The armed flag clears on leaving RUN and sets in RUN once sleep_req_i is sampled 0. A held-high sleep_req_i therefore never re-sleeps on its own.
- DRAIN -> RUN if sleep_req_i=0, which aborts the sleep. Otherwise DRAIN -> SUSP when wb_cyc_i=0.
- SUSP -> PGATE when suspended_i=1. SUSP cannot be aborted.
- PGATE: the counter loads OFF_MIN_CYC on entry and decrements to 0. PGATE -> PWRUP when cnt==0 && wake_pend.
- PWRUP: the counter loads PWRUP_CYC on entry. PWRUP -> RESTORE when cnt==0.
- RESTORE -> RESUME unconditionally, so RESTORE lasts exactly one cycle.
- RESUME -> RUN when suspended_i=0.

wake_pend:
- Set when wake_req_i=1 is sampled in DRAIN, SUSP or PGATE.
- Cleared on entry to PWRUP.
- wake_req_i is ignored in RUN, PWRUP, RESTORE and RESUME.

Counter:
- CNT_W bits; it never underflows and holds at 0.
- It is a don't-care outside PGATE and PWRUP.

Reset (async, any state, including mid-power-off):
- state=RUN, armed=0, wake_pend=0, cnt=0.
- All outputs 0, with pwr_off_o deasserted immediately on reset assertion.

## Timing
Controller handshake guarantees:
- susp_req_o rises only while suspended_i=0.
- susp_req_o falls the cycle after suspended_i is first sampled 1.
- resume_req_o rises only while suspended_i=1.
- resume_req_o falls the cycle after suspended_i is first sampled 0.

Retention pulse:
- pr_restore_o is high for exactly one cycle.
- resume_req_o rises in the cycle pr_restore_o falls.

Latencies:
- sleep_req_i rise to wb_hold_o rise: 1 cycle.
- wb_cyc_i=0 sampled in DRAIN to susp_req_o rise: 1 cycle.
- End of PGATE to pr_restore_o: PWRUP_CYC+1 cycles.

Boundary cases:
- sleep_req_i and wb_cyc_i both low in the same DRAIN cycle: the abort takes priority, so next state is RUN.
- wake_req_i arriving before PGATE is entered: power-off still occurs for the full OFF_MIN_CYC+1 cycles, then power-up proceeds.
- OFF_MIN_CYC=0 with wake pending: PGATE lasts 1 cycle.
- PWRUP_CYC=0: PWRUP lasts 1 cycle.

## Test plan
- Basic cycle, OFF_MIN_CYC=4, PWRUP_CYC=8, model asserts suspended 3 cycles after susp_req, wake_req pulsed during PGATE:
  - susp_req_o high 4 cycles.
  - pwr_off_o high ≥5 cycles.
  - PWRUP lasts 9 cycles, then a 1-cycle pr_restore_o.
  - resume_req_o rises as pr_restore_o falls and drops 1 cycle after suspended_i falls.
  - wb_hold_o returns to 0 in RUN.
- Drain: wb_cyc_i held 1 for 6 cycles after sleep_req_i -> wb_hold_o=1 throughout and susp_req_o stays 0 until the cycle after wb_cyc_i drops.
- Abort: sleep_req_i drops while in DRAIN -> return to RUN next cycle, susp_req_o never asserts, wb_hold_o=0.
- Early wake: wake_req_i pulsed 1 cycle in SUSP -> PGATE still lasts exactly 5 cycles, then the normal power-up sequence.
- Re-arm: sleep_req_i held 1 through the whole cycle -> no second DRAIN until sleep_req_i is sampled 0 then 1.
- Reset in PGATE: rst_i asserted mid-dwell -> pwr_off_o and all outputs 0 asynchronously, state RUN, a later wake_req_i has no effect.

Source files
------------

// File: rtl/mc_pm_seq.sv
// Power-management sequencer: drains WISHBONE, suspends the controller, gates power,
// then powers up, pulses retention restore and resumes. Outputs are registered state decodes.
module mc_pm_seq #(
  parameter int OFF_MIN_CYC = 4,
  parameter int PWRUP_CYC   = 8,
  parameter int CNT_W       = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sleep_req_i,
  input  logic wake_req_i,
  input  logic wb_cyc_i,
  input  logic suspended_i,
  output logic susp_req_o,
  output logic resume_req_o,
  output logic pr_restore_o,
  output logic pwr_off_o,
  output logic wb_hold_o,
  output logic asleep_o
);

  typedef enum logic [2:0] {
    S_RUN,
    S_DRAIN,
    S_SUSP,
    S_PGATE,
    S_PWRUP,
    S_RESTORE,
    S_RESUME
  } state_t;

  localparam logic [CNT_W-1:0] OFF_LD   = CNT_W'(OFF_MIN_CYC);
  localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_CYC);

  state_t           r_state;
  state_t           w_next;
  logic             r_armed;
  logic             r_wake_pend;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_zero;
  logic             w_enter_pgate;
  logic             w_enter_pwrup;
  logic             w_wake_window;

  logic r_susp_req;
  logic r_resume_req;
  logic r_pr_restore;
  logic r_pwr_off;
  logic r_wb_hold;

  assign w_cnt_zero    = (r_cnt == '0);
  assign w_enter_pgate = (w_next == S_PGATE) && (r_state != S_PGATE);
  assign w_enter_pwrup = (w_next == S_PWRUP) && (r_state != S_PWRUP);
  assign w_wake_window = (r_state == S_DRAIN) || (r_state == S_SUSP) || (r_state == S_PGATE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN:     if (sleep_req_i && r_armed) w_next = S_DRAIN;
      // An abort wins over a drained bus in the same cycle.
      S_DRAIN: begin
        if (!sleep_req_i)   w_next = S_RUN;
        else if (!wb_cyc_i) w_next = S_SUSP;
      end
      S_SUSP:    if (suspended_i) w_next = S_PGATE;
      S_PGATE:   if (w_cnt_zero && r_wake_pend) w_next = S_PWRUP;
      S_PWRUP:   if (w_cnt_zero) w_next = S_RESTORE;
      S_RESTORE: w_next = S_RESUME;
      S_RESUME:  if (!suspended_i) w_next = S_RUN;
      default:   w_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_enter_pgate) begin
      r_cnt <= OFF_LD;
    end else if (w_enter_pwrup) begin
      r_cnt <= PWRUP_LD;
    end else if (!w_cnt_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A held sleep request must be seen low in RUN before it can trigger another sleep.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_armed <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (w_next != S_RUN)   r_armed <= 1'b0;
      else if (!sleep_req_i) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wake_pend <= 1'b0;
    end else if (w_enter_pwrup) begin
      r_wake_pend <= 1'b0;
    end else if (wake_req_i && w_wake_window) begin
      r_wake_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_susp_req   <= 1'b0;
      r_resume_req <= 1'b0;
      r_pr_restore <= 1'b0;
      r_pwr_off    <= 1'b0;
      r_wb_hold    <= 1'b0;
    end else begin
      r_susp_req   <= (w_next == S_SUSP);
      r_resume_req <= (w_next == S_RESUME);
      r_pr_restore <= (w_next == S_RESTORE);
      r_pwr_off    <= (w_next == S_PGATE);
      r_wb_hold    <= (w_next != S_RUN);
    end
  end

  assign susp_req_o   = r_susp_req;
  assign resume_req_o = r_resume_req;
  assign pr_restore_o = r_pr_restore;
  assign pwr_off_o    = r_pwr_off;
  assign asleep_o     = r_pwr_off;
  assign wb_hold_o    = r_wb_hold;

endmodule

// File: tb/tb_mc_pm_seq.sv
// Bench for mc_pm_seq: drives sleep/wake sequences with a small controller model and
// checks pulse widths and latencies against values derived from the sequencing rules.
module tb_mc_pm_seq;

  localparam int OFF_MIN = 4;
  localparam int PWRUP   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sleep_req = 1'b0;
  logic wake_req = 1'b0;
  logic wb_cyc = 1'b0;
  logic suspended = 1'b0;
  logic susp_req, resume_req, pr_restore, pwr_off, wb_hold, asleep;

  int checks = 0;
  int errors = 0;

  mc_pm_seq #(.OFF_MIN_CYC(OFF_MIN), .PWRUP_CYC(PWRUP), .CNT_W(8)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .sleep_req_i(sleep_req),
    .wake_req_i(wake_req),
    .wb_cyc_i(wb_cyc),
    .suspended_i(suspended),
    .susp_req_o(susp_req),
    .resume_req_o(resume_req),
    .pr_restore_o(pr_restore),
    .pwr_off_o(pwr_off),
    .wb_hold_o(wb_hold),
    .asleep_o(asleep)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [5:0] outs();
    return {susp_req, resume_req, pr_restore, pwr_off, wb_hold, asleep};
  endfunction

  // Full sleep/wake round trip. L: drain cycles with wb_cyc high, D: SUSP cycles before
  // the controller answers, k: PGATE sample on which wake pulses, R: RESUME cycles.
  task automatic sleep_cycle(input int L, input int D, input int k, input int R, input bit early);
    int n;
    int exp_pg;
    exp_pg = early ? OFF_MIN + 1 : ((k + 1 > OFF_MIN + 1) ? k + 1 : OFF_MIN + 1);
    wake_req  = 1'b0;
    sleep_req = 1'b1;
    wb_cyc    = 1'b1;
    for (int i = 0; i < L; i++) begin
      tick();
      checks++;
      if ({wb_hold, susp_req} !== 2'b10) begin
        errors++;
        $display("FAIL drain_hold step %0d got hold=%b susp=%b want hold=1 susp=0", i, wb_hold, susp_req);
      end
    end
    wb_cyc = 1'b0;
    tick();
    checks++;
    if (susp_req !== 1'b1) begin
      errors++;
      $display("FAIL susp_latency got %b want 1", susp_req);
    end
    n = 0;
    for (int g = 0; g < 100; g++) begin
      if (!susp_req) break;
      n++;
      wake_req = early && (n == 1);
      if (n == D) suspended = 1'b1;
      tick();
    end
    wake_req = 1'b0;
    checks++;
    if (n !== D) begin
      errors++;
      $display("FAIL susp_width got %0d want %0d", n, D);
    end
    n = 0;
    for (int g = 0; g < 100; g++) begin
      if (!pwr_off) break;
      n++;
      checks++;
      if (asleep !== 1'b1) begin
        errors++;
        $display("FAIL asleep_flag got %b want 1", asleep);
      end
      wake_req = !early && (n == k);
      tick();
    end
    wake_req = 1'b0;
    checks++;
    if (n !== exp_pg) begin
      errors++;
      $display("FAIL pgate_width got %0d want %0d", n, exp_pg);
    end
    n = 0;
    for (int g = 0; g < 100; g++) begin
      if (pr_restore) break;
      n++;
      tick();
    end
    checks++;
    if (n !== PWRUP + 1) begin
      errors++;
      $display("FAIL pwrup_len got %0d want %0d", n, PWRUP + 1);
    end
    tick();
    checks++;
    if ({pr_restore, resume_req} !== 2'b01) begin
      errors++;
      $display("FAIL restore_pulse got restore=%b resume=%b want 0 1", pr_restore, resume_req);
    end
    n = 0;
    for (int g = 0; g < 100; g++) begin
      if (!resume_req) break;
      n++;
      if (n == R) suspended = 1'b0;
      tick();
    end
    checks++;
    if (n !== R) begin
      errors++;
      $display("FAIL resume_width got %0d want %0d", n, R);
    end
    checks++;
    if (outs() !== 6'b0) begin
      errors++;
      $display("FAIL run_outputs got %b want 000000", outs());
    end
  endtask

  task automatic arm();
    sleep_req = 1'b0;
    wb_cyc    = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (outs() !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 000000", outs());
    end
    rst = 1'b0;
    sleep_req = 1'b1;
    tick();
    tick();
    checks++;
    if (wb_hold !== 1'b0) begin
      errors++;
      $display("FAIL unarmed_after_reset got hold=%b want 0", wb_hold);
    end
    arm();
  endtask

  task automatic test_basic();
    arm();
    sleep_cycle(1, 4, 2, 2, 1'b0);
  endtask

  task automatic test_drain();
    arm();
    sleep_cycle(6, 3, 1, 1, 1'b0);
  endtask

  task automatic test_early_wake();
    arm();
    sleep_cycle(2, 2, 0, 3, 1'b1);
  endtask

  task automatic test_abort();
    arm();
    sleep_req = 1'b1;
    wb_cyc    = 1'b1;
    tick();
    checks++;
    if (wb_hold !== 1'b1) begin
      errors++;
      $display("FAIL abort_enter got hold=%b want 1", wb_hold);
    end
    sleep_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({susp_req, wb_hold} !== 2'b00) begin
        errors++;
        $display("FAIL abort_return step %0d got susp=%b hold=%b want 0 0", i, susp_req, wb_hold);
      end
    end
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    wb_cyc    = 1'b0;
    tick();
    checks++;
    if ({susp_req, wb_hold} !== 2'b00) begin
      errors++;
      $display("FAIL abort_priority got susp=%b hold=%b want 0 0", susp_req, wb_hold);
    end
  endtask

  task automatic test_rearm();
    arm();
    sleep_cycle(1, 1, 5, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (wb_hold !== 1'b0) begin
        errors++;
        $display("FAIL rearm_held step %0d got hold=%b want 0", i, wb_hold);
      end
    end
    sleep_req = 1'b0;
    tick();
    sleep_req = 1'b1;
    wb_cyc    = 1'b1;
    tick();
    checks++;
    if (wb_hold !== 1'b1) begin
      errors++;
      $display("FAIL rearm_resleep got hold=%b want 1", wb_hold);
    end
    sleep_req = 1'b0;
    wb_cyc    = 1'b0;
    tick();
  endtask

  task automatic test_reset_pgate();
    arm();
    sleep_req = 1'b1;
    tick();
    tick();
    suspended = 1'b1;
    tick();
    tick();
    checks++;
    if (pwr_off !== 1'b1) begin
      errors++;
      $display("FAIL pgate_before_reset got %b want 1", pwr_off);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (outs() !== 6'b0) begin
      errors++;
      $display("FAIL reset_async got %b want 000000", outs());
    end
    suspended = 1'b0;
    sleep_req = 1'b0;
    tick();
    rst = 1'b0;
    wake_req = 1'b1;
    tick();
    wake_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (outs() !== 6'b0) begin
        errors++;
        $display("FAIL wake_after_reset step %0d got %b want 000000", i, outs());
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      arm();
      sleep_cycle($urandom_range(6, 1), $urandom_range(6, 1), $urandom_range(8, 1),
                  $urandom_range(5, 1), 1'($urandom_range(1, 0)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drain();
    test_early_wake();
    test_abort();
    test_rearm();
    test_random();
    test_reset_pgate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
